// File: rtl/spi_master_reader.sv
// spi_master_reader: SPI mode-0 master reading NUM_BYTES-byte frames MSB first; define SPI_MASTER_MISO_SYNC_EN to pass MISO through a 2-flop synchroniser
module spi_master_reader #(
  parameter int CLK_DIV    = 4,
  parameter int NUM_BYTES  = 4,
  parameter int CSS_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       SCK,
  output logic       SSEL,
  output logic       MOSI,
  input  logic       MISO,
  input  logic [7:0] tx_data,
  output logic       tx_next,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_done
);
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD} state_t;
  localparam logic [7:0] DIV_END   = 8'(CLK_DIV - 1);
  localparam logic [7:0] CSS_END   = 8'(CSS_CYCLES - 1);
  localparam logic [7:0] LAST_BYTE = 8'(NUM_BYTES - 1);
  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_byte;
  logic [7:0] r_tx;
  logic [7:0] r_sh;
  logic [2:0] r_bit;
  logic       w_miso;
`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam logic [7:0] SAMPLE = 8'd2;
  logic [1:0] r_sync;
  // two-flop synchroniser for an asynchronous slave; sampling point moves two cycles into HIGH
  always_ff @(posedge clk) r_sync <= rst ? 2'b00 : {r_sync[0], MISO};
  assign w_miso = r_sync[1];
`else
  localparam logic [7:0] SAMPLE = 8'd0;
  assign w_miso = MISO;
`endif
  // frame sequencer: chip-select setup, CLK_DIV-cycle SCK halves, byte bookkeeping, chip-select hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_byte     <= '0;
      r_tx       <= '0;
      r_sh       <= '0;
      r_bit      <= '0;
      busy       <= 1'b0;
      SCK        <= 1'b0;
      SSEL       <= 1'b1;
      MOSI       <= 1'b1;
      tx_next    <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_next    <= 1'b0;
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
      r_cnt      <= r_cnt + 8'd1;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (start) begin
            r_state <= SETUP;
            SSEL    <= 1'b0;
            busy    <= 1'b1;
            r_tx    <= tx_data;
            MOSI    <= tx_data[7];
            tx_next <= 1'b1;
            r_bit   <= '0;
            r_byte  <= '0;
          end
        end
        SETUP: if (r_cnt == CSS_END) begin
          r_state <= LOW;
          r_cnt   <= '0;
        end
        LOW: if (r_cnt == DIV_END) begin
          r_state <= HIGH;
          SCK     <= 1'b1;
          r_cnt   <= '0;
        end
        HIGH: begin
          if (r_cnt == SAMPLE) begin
            r_sh <= {r_sh[6:0], w_miso};
            if (r_bit == 3'd7) begin
              rx_data  <= {r_sh[6:0], w_miso};
              rx_valid <= 1'b1;
            end
          end
          if (r_cnt == DIV_END) begin
            SCK     <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= r_bit + 3'd1;
            r_tx    <= {r_tx[6:0], 1'b0};
            MOSI    <= r_tx[6];
            r_state <= LOW;
            if (r_bit == 3'd7) begin
              if (r_byte == LAST_BYTE) begin
                r_state <= HOLD;
              end else begin
                r_byte  <= r_byte + 8'd1;
                r_tx    <= tx_data;
                MOSI    <= tx_data[7];
                tx_next <= 1'b1;
              end
            end
          end
        end
        HOLD: if (r_cnt == CSS_END) begin
          r_state    <= IDLE;
          r_cnt      <= '0;
          SSEL       <= 1'b1;
          MOSI       <= 1'b1;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_reader.sv
// tb_spi_master_reader: directed bench with mode-0 slave models for a 4-byte and a 1-byte reader
module tb_spi_master_reader;
  localparam int CD  = 4;
  localparam int CSS = 2;
`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam int SAMP = 2;
`else
  localparam int SAMP = 0;
`endif
  localparam int NV = 20;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] miso;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;
  vec_t vec [NV];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] miso_of(input int i);
    return (i < NV) ? vec[i].miso : 8'hFF;
  endfunction

  logic       s4_start, s4_busy, s4_sck, s4_ssel, s4_mosi, s4_miso, s4_txn, s4_rxv, s4_fd;
  logic [7:0] s4_tx, s4_rx;
  logic       s1_start, s1_busy, s1_sck, s1_ssel, s1_mosi, s1_miso, s1_txn, s1_rxv, s1_fd;
  logic [7:0] s1_rx;

  int tidx, ridx, sidx, midx;
  int n_txn4 = 0, n_rxv4 = 0, n_fd4 = 0;

  assign s4_tx = (tidx < NV) ? vec[tidx].tx : 8'h00;

  spi_master_reader #(.CLK_DIV(CD), .NUM_BYTES(4), .CSS_CYCLES(CSS)) u4 (
    .clk(clk), .rst(rst), .start(s4_start), .busy(s4_busy), .SCK(s4_sck), .SSEL(s4_ssel),
    .MOSI(s4_mosi), .MISO(s4_miso), .tx_data(s4_tx), .tx_next(s4_txn), .rx_data(s4_rx),
    .rx_valid(s4_rxv), .frame_done(s4_fd));

  spi_master_reader #(.CLK_DIV(CD), .NUM_BYTES(1), .CSS_CYCLES(CSS)) u1 (
    .clk(clk), .rst(rst), .start(s1_start), .busy(s1_busy), .SCK(s1_sck), .SSEL(s1_ssel),
    .MOSI(s1_mosi), .MISO(s1_miso), .tx_data(8'h96), .tx_next(s1_txn), .rx_data(s1_rx),
    .rx_valid(s1_rxv), .frame_done(s1_fd));

  // tx feed and received-byte scoreboard for the 4-byte reader
  always @(negedge clk) begin
    if (s4_txn) n_txn4 <= n_txn4 + 1;
    if (s4_fd) n_fd4 <= n_fd4 + 1;
    if (s4_rxv) n_rxv4 <= n_rxv4 + 1;
    if (rst) begin
      tidx <= 0;
      ridx <= 0;
    end else begin
      if (s4_txn) tidx <= tidx + 1;
      if (s4_rxv) begin
        check("rx_data4", {24'd0, s4_rx}, {24'd0, (ridx < NV) ? vec[ridx].exp_rx : 8'hFF});
        ridx <= ridx + 1;
      end
    end
  end

  // mode-0 slave for the 4-byte reader: drives MISO after falls, captures MOSI on rises
  logic       p_sck4, p_ssel4;
  logic [7:0] sh4, cap4;
  int         bit4, capn4;
  always @(negedge clk) begin
    p_sck4  <= s4_sck;
    p_ssel4 <= s4_ssel;
    if (rst) begin
      sidx <= 0; midx <= 0; capn4 <= 0; bit4 <= 0; sh4 <= 8'h00; s4_miso <= 1'b1;
    end else begin
      if (p_ssel4 && !s4_ssel) begin
        sh4 <= miso_of(sidx); s4_miso <= miso_of(sidx)[7]; bit4 <= 0;
      end
      if (!p_sck4 && s4_sck) begin
        cap4 <= {cap4[6:0], s4_mosi};
        if (capn4 == 7) begin
          check("mosi4", {24'd0, cap4[6:0], s4_mosi}, {24'd0, (midx < NV) ? vec[midx].exp_mosi : 8'hFF});
          midx <= midx + 1; capn4 <= 0;
        end else capn4 <= capn4 + 1;
      end
      if (p_sck4 && !s4_sck) begin
        if (bit4 == 7) begin
          sidx <= sidx + 1; sh4 <= miso_of(sidx + 1); s4_miso <= miso_of(sidx + 1)[7]; bit4 <= 0;
        end else begin
          sh4 <= {sh4[6:0], 1'b0}; s4_miso <= sh4[6]; bit4 <= bit4 + 1;
        end
      end
    end
  end

  // mode-0 slave for the 1-byte reader: always returns 8'hA5
  logic       p_sck1, p_ssel1;
  logic [7:0] sh1;
  always @(negedge clk) begin
    p_sck1  <= s1_sck;
    p_ssel1 <= s1_ssel;
    if (rst) begin
      s1_miso <= 1'b1; sh1 <= 8'h00;
    end else if (p_ssel1 && !s1_ssel) begin
      sh1 <= 8'hA5; s1_miso <= 1'b1;
    end else if (p_sck1 && !s1_sck) begin
      sh1 <= {sh1[6:0], 1'b0}; s1_miso <= sh1[6];
    end
  end

  task automatic wait_fd4(input string name);
    int n;
    n = 0;
    while (!s4_fd && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!s4_fd) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int b_txn, b_rxv, b_fd, n, nsck, rise8, rxv_at, nrxv1, gap;
    logic prev;
    vec[0] = '{8'hC3, 8'h01, 8'h01, 8'hC3};
    vec[1] = '{8'h3C, 8'h02, 8'h02, 8'h3C};
    vec[2] = '{8'hFF, 8'h03, 8'h03, 8'hFF};
    vec[3] = '{8'h00, 8'h04, 8'h04, 8'h00};
    vec[4] = '{8'h5A, 8'h80, 8'h80, 8'h5A};
    vec[5] = '{8'h81, 8'h01, 8'h01, 8'h81};
    vec[6] = '{8'h7E, 8'h7F, 8'h7F, 8'h7E};
    vec[7] = '{8'h01, 8'hFE, 8'hFE, 8'h01};
    for (int i = 8; i < NV; i++) vec[i] = '{8'(i * 29 + 3), 8'(i * 53 + 11), 8'(i * 53 + 11), 8'(i * 29 + 3)};
    s4_start = 1'b0;
    s1_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset4_ctl", {s4_sck, s4_ssel, s4_mosi, s4_busy, s4_txn, s4_rxv, s4_fd}, 7'b0110000);
    check("reset4_rx", s4_rx, 8'h00);
    check("reset1_ctl", {s1_sck, s1_ssel, s1_mosi, s1_busy, s1_txn, s1_rxv, s1_fd}, 7'b0110000);
    rst = 1'b0;
    @(negedge clk);
    // reset in the middle of the second byte of a frame
    s4_start = 1'b1;
    @(negedge clk);
    s4_start = 1'b0;
    check("start_accept", {s4_busy, s4_ssel, s4_txn}, 3'b101);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", {s4_sck, s4_ssel, s4_mosi, s4_busy, s4_rxv, s4_fd}, 6'b011000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b_rxv = n_rxv4; b_fd = n_fd4;
    repeat (300) @(negedge clk);
    check("rst_no_rxv", n_rxv4 - b_rxv, 0);
    check("rst_no_fd", n_fd4 - b_fd, 0);
    check("rst_idle", {s4_ssel, s4_busy}, 2'b10);
    // single-byte frame: timing, SCK pulses and rx_valid latency
    s1_start = 1'b1;
    n = 1; nsck = 0; rise8 = 0; rxv_at = 0; nrxv1 = 0; prev = s1_sck;
    while (!s1_fd && n < 500) begin
      @(negedge clk);
      s1_start = 1'b0;
      n++;
      if (!prev && s1_sck) begin
        nsck++;
        if (nsck == 8) rise8 = n;
      end
      prev = s1_sck;
      if (s1_rxv) begin
        nrxv1++; rxv_at = n;
        check("rx1", s1_rx, 8'hA5);
      end
    end
    check("fd1_cycles", n, 2 * CSS + 16 * CD + 2);
    check("sck1_pulses", nsck, 8);
    check("rxv1_count", nrxv1, 1);
    check("rxv1_latency", rxv_at - rise8, 1 + SAMP);
    check("rx1_hold", s1_rx, 8'hA5);
    check("fd1_state", {s1_ssel, s1_busy, s1_mosi}, 3'b101);
    // two 4-byte frames: C3,3C,FF,00 / 01..04 then 5A.. / 80,01,7F,FE
    for (int f = 0; f < 2; f++) begin
      b_txn = n_txn4; b_rxv = n_rxv4; b_fd = n_fd4;
      s4_start = 1'b1;
      @(negedge clk);
      s4_start = 1'b0;
      wait_fd4("frame4");
      repeat (2) @(negedge clk);
      check("txn4_count", n_txn4 - b_txn, 4);
      check("rxv4_count", n_rxv4 - b_rxv, 4);
      check("fd4_count", n_fd4 - b_fd, 1);
    end
    check("rx4_last", s4_rx, 8'hFE);
    // start toggled every cycle during a frame yields one frame
    b_fd = n_fd4;
    s4_start = 1'b1;
    n = 0;
    while (!s4_fd && n < 1000) begin
      @(negedge clk);
      n++;
      s4_start = ~s4_start;
    end
    s4_start = 1'b0;
    repeat (40) @(negedge clk);
    check("pulsed_one_frame", n_fd4 - b_fd, 1);
    check("pulsed_idle", {s4_ssel, s4_busy}, 2'b10);
    // start held high gives back-to-back frames with a single SSEL-high cycle
    b_fd = n_fd4;
    s4_start = 1'b1;
    @(negedge clk);
    wait_fd4("held1");
    gap = 1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (!s4_ssel) break;
      gap++;
    end
    check("ssel_gap", gap, 1);
    @(negedge clk);
    wait_fd4("held2");
    s4_start = 1'b0;
    repeat (40) @(negedge clk);
    check("held_two_frames", n_fd4 - b_fd, 2);
    check("held_rx_all", ridx, NV);
    check("held_mosi_all", midx, NV);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
